uart_packet_loader: RTL and testbench



---
 rtl/uart_packet_loader.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_uart_packet_loader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_loader.sv
// uart_packet_loader: 8N1 UART receiver plus packet framer that verifies a checksummed packet before replaying it as writes.
// Latency: the first write is offered two cycles after the last payload byte strobe; then one write per cycle under continuous ready.
// Backpressure: writes hold addr/data while wr_ready is low; bytes arriving during the write phase are dropped and set overrun.
//
// Ports:
//   clk, RESET_N (async active-low)  UART_RX (async serial in, idle high)
//   wr_addr/wr_data/wr_valid/wr_ready  verified-packet write port
//   pkt_done, cksum_err, frame_err, len_err, timeout_err  one-cycle status pulses
//   overrun (sticky until reset), busy (low only while waiting for a checksum byte)
module uart_packet_loader #(
    parameter int CLKS_PER_BIT = 100,
    parameter int ADDR_W       = 8,
    parameter int MAX_LEN      = 256,
    parameter int AUTO_INC     = 1,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic              clk,
    input  logic              RESET_N,
    input  logic              UART_RX,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              pkt_done,
    output logic              cksum_err,
    output logic              frame_err,
    output logic              len_err,
    output logic              timeout_err,
    output logic              overrun,
    output logic              busy
);

    localparam int HALF   = CLKS_PER_BIT / 2;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    localparam logic [CNT_W-1:0] C_S0  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] C_S1  = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] C_S2  = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] C_END = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [9:0]       MAX_LEN_V = 10'(MAX_LEN);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        r_rx_state;
    logic             r_rx_meta, r_rx_sync, r_rx_prev;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [2:0]       r_bit_idx;
    logic [1:0]       r_votes;
    logic             r_bit_val;
    logic [7:0]       r_shift;
    logic             r_byte_vld;
    logic [7:0]       r_byte_dat;
    logic             r_ferr;
    logic             w_vote;

    // Third sample joins the two already counted: majority of three.
    assign w_vote = (r_votes + {1'b0, r_rx_sync}) >= 2'd2;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_votes    <= '0;
            r_bit_val  <= 1'b0;
            r_shift    <= '0;
            r_byte_vld <= 1'b0;
            r_byte_dat <= '0;
            r_ferr     <= 1'b0;
        end else begin
            r_rx_meta  <= UART_RX;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_byte_vld <= 1'b0;
            r_ferr     <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    // The edge cycle itself is cycle 0 of the start bit.
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RX_START;
                        r_bit_cnt  <= CNT_W'(1);
                    end
                end
                default: begin
                    r_bit_cnt <= (r_bit_cnt == C_END) ? '0 : r_bit_cnt + 1'b1;
                    if (r_bit_cnt == C_S0) r_votes <= {1'b0, r_rx_sync};
                    if (r_bit_cnt == C_S1) r_votes <= r_votes + {1'b0, r_rx_sync};
                    if (r_bit_cnt == C_S2) begin
                        r_bit_val <= w_vote;
                        // Stop bit is resolved at its last sample so the receiver is
                        // idle well before the next start edge can appear.
                        if (r_rx_state == RX_STOP) begin
                            r_rx_state <= RX_IDLE;
                            if (w_vote) begin
                                r_byte_vld <= 1'b1;
                                r_byte_dat <= r_shift;
                            end else begin
                                r_ferr <= 1'b1;
                            end
                        end
                    end
                    if (r_bit_cnt == C_END) begin
                        case (r_rx_state)
                            RX_START: begin
                                r_bit_idx  <= '0;
                                r_rx_state <= r_bit_val ? RX_IDLE : RX_DATA;
                            end
                            RX_DATA: begin
                                r_shift   <= {r_bit_val, r_shift[7:1]};
                                r_bit_idx <= r_bit_idx + 1'b1;
                                if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_HDR_CK, S_HDR_ADDR, S_HDR_CNT, S_PAYLOAD, S_COMMIT, S_DRAIN
    } pkt_state_t;

    pkt_state_t        r_state;
    logic [7:0]        r_sum;
    logic [ADDR_W-1:0] r_base;
    logic [8:0]        r_len;
    logic [8:0]        r_idx;
    logic [7:0]        r_buf [MAX_LEN];
    logic              r_wr_vld;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_dat;
    logic              r_pkt_done, r_cksum_err, r_len_err, r_to_err, r_overrun;
    logic [TO_W-1:0]   r_to_cnt;

    logic [7:0] w_sum_nxt;
    logic [8:0] w_cnt_len;
    logic [8:0] w_idx_inc;
    logic       w_last;
    logic       w_to_run;
    logic       w_to_fire;

    assign w_sum_nxt = r_sum + r_byte_dat;
    assign w_cnt_len = {1'b0, r_byte_dat} + 9'd1;
    assign w_idx_inc = r_idx + 9'd1;
    assign w_last    = (r_idx == r_len - 9'd1);
    assign w_to_run  = (r_state == S_HDR_ADDR) || (r_state == S_HDR_CNT) ||
                       (r_state == S_PAYLOAD)  || (r_state == S_DRAIN);
    assign w_to_fire = (TIMEOUT_BITS != 0) && w_to_run && (r_to_cnt == TO_LAST);

    // Inter-byte timer: restarts on every byte and whenever it is not armed.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_to_cnt <= '0;
        end else if (r_byte_vld || !w_to_run) begin
            r_to_cnt <= '0;
        end else if (!w_to_fire) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Payload store; a slot is always written before it is read back.
    always_ff @(posedge clk) begin
        if (r_state == S_PAYLOAD && r_byte_vld)
            r_buf[r_idx[IDX_W-1:0]] <= r_byte_dat;
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_HDR_CK;
            r_sum       <= '0;
            r_base      <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_wr_vld    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_dat    <= '0;
            r_pkt_done  <= 1'b0;
            r_cksum_err <= 1'b0;
            r_len_err   <= 1'b0;
            r_to_err    <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_pkt_done  <= 1'b0;
            r_cksum_err <= 1'b0;
            r_len_err   <= 1'b0;
            r_to_err    <= 1'b0;
            if (r_ferr && r_state != S_HDR_CK) begin
                r_state  <= S_HDR_CK;
                r_sum    <= '0;
                r_wr_vld <= 1'b0;
            end else if (r_state == S_COMMIT) begin
                if (r_byte_vld) r_overrun <= 1'b1;
                if (!r_wr_vld) begin
                    // First cycle of the write phase: present entry 0.
                    r_wr_vld  <= 1'b1;
                    r_wr_dat  <= r_buf[r_idx[IDX_W-1:0]];
                    r_wr_addr <= r_base;
                end else if (wr_ready) begin
                    if (w_last) begin
                        r_wr_vld   <= 1'b0;
                        r_pkt_done <= 1'b1;
                        r_state    <= S_HDR_CK;
                        r_sum      <= '0;
                    end else begin
                        r_idx    <= w_idx_inc;
                        r_wr_dat <= r_buf[w_idx_inc[IDX_W-1:0]];
                        if (AUTO_INC != 0) r_wr_addr <= r_wr_addr + 1'b1;
                    end
                end
            end else if (r_byte_vld) begin
                r_sum <= w_sum_nxt;
                case (r_state)
                    S_HDR_CK:   r_state <= S_HDR_ADDR;
                    S_HDR_ADDR: begin
                        r_base  <= ADDR_W'(r_byte_dat);
                        r_state <= S_HDR_CNT;
                    end
                    S_HDR_CNT: begin
                        r_len   <= w_cnt_len;
                        r_idx   <= '0;
                        r_state <= ({1'b0, w_cnt_len} > MAX_LEN_V) ? S_DRAIN : S_PAYLOAD;
                    end
                    S_PAYLOAD: begin
                        r_idx <= w_idx_inc;
                        if (w_last) begin
                            r_idx <= '0;
                            if (w_sum_nxt == 8'd0) begin
                                r_state <= S_COMMIT;
                            end else begin
                                r_cksum_err <= 1'b1;
                                r_state     <= S_HDR_CK;
                                r_sum       <= '0;
                            end
                        end
                    end
                    S_DRAIN: begin
                        r_idx <= w_idx_inc;
                        if (w_last) begin
                            r_len_err <= 1'b1;
                            r_state   <= S_HDR_CK;
                            r_sum     <= '0;
                        end
                    end
                    default: r_state <= S_HDR_CK;
                endcase
            end else if (w_to_fire) begin
                r_to_err <= 1'b1;
                r_state  <= S_HDR_CK;
                r_sum    <= '0;
            end
        end
    end

    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_dat;
    assign wr_valid    = r_wr_vld;
    assign pkt_done    = r_pkt_done;
    assign cksum_err   = r_cksum_err;
    assign frame_err   = r_ferr;
    assign len_err     = r_len_err;
    assign timeout_err = r_to_err;
    assign overrun     = r_overrun;
    assign busy        = (r_state != S_HDR_CK);

endmodule

// File: tb/tb_uart_packet_loader.sv
// Bench for uart_packet_loader: packets are serialised onto UART_RX, the expected
// writes and status pulses are queued from packet rules, and a monitor pops them
// as the DUT presents them.
module tb_uart_packet_loader;

    localparam int CPB     = 8;
    localparam int ADDR_W  = 8;
    localparam int MAX_LEN = 16;
    localparam int TO_BITS = 40;

    localparam int EV_DONE  = 0;
    localparam int EV_CKSUM = 1;
    localparam int EV_FRAME = 2;
    localparam int EV_LEN   = 3;
    localparam int EV_TMO   = 4;

    logic clk      = 1'b0;
    logic RESET_N  = 1'b0;
    logic UART_RX  = 1'b1;
    logic wr_ready = 1'b0;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic wr_valid, pkt_done, cksum_err, frame_err, len_err, timeout_err, overrun, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int ready_mode = 0;            // 0: always ready, 1: random, 2: held low
    logic [15:0] exp_wr_q[$];      // {addr, data}
    int          exp_ev_q[$];
    logic [7:0]  pl_q[$];          // payload of the next packet to send

    always #5 clk = ~clk;

    uart_packet_loader #(
        .CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN),
        .AUTO_INC(1), .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .clk(clk), .RESET_N(RESET_N), .UART_RX(UART_RX),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .pkt_done(pkt_done), .cksum_err(cksum_err), .frame_err(frame_err),
        .len_err(len_err), .timeout_err(timeout_err), .overrun(overrun), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ev(input logic pulse, input int code, input string name);
        int e;
        if (pulse) begin
            if (exp_ev_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: pulse seen, no event expected", name);
            end else begin
                e = exp_ev_q.pop_front();
                check(name, code, e);
            end
        end
    endtask

    // Ready generator
    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = 1'($urandom_range(0, 1));
                default: wr_ready = 1'b0;
            endcase
        end
    end

    // Monitor: samples one time unit after the falling edge, when inputs for the
    // next rising edge are settled and outputs are stable.
    initial begin : monitor
        logic        prev_stall;
        logic [15:0] prev_wr;
        logic [15:0] e;
        prev_stall = 1'b0;
        prev_wr    = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!RESET_N) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && wr_valid)
                    check("stall_hold", {wr_addr, wr_data}, prev_wr);
                prev_stall = wr_valid && !wr_ready;
                prev_wr    = {wr_addr, wr_data};
                if (wr_valid && wr_ready) begin
                    if (exp_wr_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL write: got addr 0x%0h data 0x%0h, no write expected", wr_addr, wr_data);
                    end else begin
                        e = exp_wr_q.pop_front();
                        check("write", {wr_addr, wr_data}, e);
                    end
                end
                check_ev(pkt_done,    EV_DONE,  "pkt_done");
                check_ev(cksum_err,   EV_CKSUM, "cksum_err");
                check_ev(frame_err,   EV_FRAME, "frame_err");
                check_ev(len_err,     EV_LEN,   "len_err");
                check_ev(timeout_err, EV_TMO,   "timeout_err");
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input logic stop);
        UART_RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            UART_RX = d[i];
            repeat (CPB) @(negedge clk);
        end
        UART_RX = stop;
        repeat (CPB) @(negedge clk);
        UART_RX = 1'b1;
    endtask

    // Sends checksum|addr|count|payload(pl_q) and queues what the loader must do.
    // ck_delta = 0 gives a checksum that makes the byte sum zero.
    task automatic send_packet(input logic [7:0] addr, input logic [7:0] ck_delta);
        logic [7:0] bytes[$];
        logic [7:0] a;
        int s;
        int len;
        len = pl_q.size();
        bytes.push_back(8'h00);
        bytes.push_back(addr);
        bytes.push_back(8'(len - 1));
        foreach (pl_q[i]) bytes.push_back(pl_q[i]);
        s = 0;
        foreach (bytes[i]) s += bytes[i];
        bytes[0] = 8'(256 - (s % 256)) + ck_delta;
        s = 0;
        foreach (bytes[i]) s += bytes[i];
        if (len > MAX_LEN) begin
            exp_ev_q.push_back(EV_LEN);
        end else if (s % 256 != 0) begin
            exp_ev_q.push_back(EV_CKSUM);
        end else begin
            for (int i = 0; i < len; i++) begin
                a = addr + 8'(i);
                exp_wr_q.push_back({a, pl_q[i]});
            end
            exp_ev_q.push_back(EV_DONE);
        end
        foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    endtask

    task automatic rand_payload(input int len);
        pl_q.delete();
        for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (CPB) @(negedge clk);
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, busy, 0);
        repeat (3) @(negedge clk);
        check({name, "_writes_left"}, exp_wr_q.size(), 0);
        check({name, "_events_left"}, exp_ev_q.size(), 0);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!wr_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, wr_valid, 1);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_pulses", {pkt_done, cksum_err, frame_err, len_err, timeout_err}, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        RESET_N = 1'b1;
        repeat (4) @(negedge clk);

        // Good packet, three bytes to 0x10.. with continuous ready
        ready_mode = 0;
        pl_q = '{8'h11, 8'h22, 8'h3F};
        send_packet(8'h10, 8'h00);
        wait_idle("good");

        // Corrupted checksum, then a clean packet
        pl_q = '{8'h11, 8'h22, 8'h3F};
        send_packet(8'h10, 8'h01);
        wait_idle("bad_ck");
        rand_payload(4);
        send_packet(8'h40, 8'h00);
        wait_idle("after_bad_ck");

        // Address wrap under random backpressure
        ready_mode = 1;
        rand_payload(2);
        send_packet(8'hFF, 8'h00);
        wait_idle("wrap");

        // Length above MAX_LEN is drained, then a normal packet
        ready_mode = 0;
        rand_payload(MAX_LEN + 5);
        send_packet(8'h20, 8'h00);
        wait_idle("len");
        rand_payload(MAX_LEN);
        send_packet(8'h80, 8'h00);
        wait_idle("after_len");

        // Stop bit low on the address byte
        exp_ev_q.push_back(EV_FRAME);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        wait_idle("frame");

        // Line goes quiet after the count byte
        exp_ev_q.push_back(EV_TMO);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h03, 1'b1);
        repeat (4) @(negedge clk);
        check("tmo_busy_after_cnt", busy, 1);
        repeat (36 * CPB) @(negedge clk);
        check("tmo_not_early", busy, 1);
        for (int i = 0; i < 8 * CPB && busy; i++) @(negedge clk);
        check("tmo_busy_dropped", busy, 0);
        wait_idle("tmo");

        // Byte arrives while the write phase is stalled
        ready_mode = 2;
        rand_payload(3);
        send_packet(8'h30, 8'h00);
        wait_valid("ovr");
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        check("overrun_set", overrun, 1);
        check("ovr_still_valid", wr_valid, 1);
        ready_mode = 0;
        wait_idle("ovr");
        check("overrun_sticky", overrun, 1);

        // Reset in the middle of a stalled write phase
        ready_mode = 2;
        rand_payload(4);
        send_packet(8'h50, 8'h00);
        wait_valid("rst_commit");
        @(negedge clk);
        #3;
        RESET_N = 1'b0;
        #1;
        check("rst_commit_valid", wr_valid, 0);
        check("rst_commit_overrun", overrun, 0);
        check("rst_commit_busy", busy, 0);
        exp_wr_q.delete();
        exp_ev_q.delete();
        repeat (3) @(negedge clk);
        RESET_N = 1'b1;
        ready_mode = 0;
        repeat (4) @(negedge clk);
        rand_payload(5);
        send_packet(8'h60, 8'h00);
        wait_idle("after_rst");

        // Randomised packets: lengths straddle MAX_LEN, some checksums corrupted
        ready_mode = 1;
        for (int p = 0; p < 20; p++) begin
            rand_payload($urandom_range(1, MAX_LEN + 4));
            send_packet(8'($urandom_range(0, 255)),
                        ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            wait_idle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
